// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   uart_rx_state_t : receiver FSM state encoding
//   par_calc()      : parity bit a transmitter would send for a data word
//   start_mid_idx() : tick index of the start-bit centre
//   bit_centre_idx(): tick index of a data/parity/stop bit centre
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    // Words narrower than 8 bits are zero-extended by the caller, which
    // leaves the XOR reduction unchanged.
    // ptype = 0 : even (bit = ^data), ptype = 1 : odd (bit = ~^data)
    function automatic logic par_calc(input logic [7:0] data, input logic ptype);
        return ptype ? ~(^data) : (^data);
    endfunction

    // Start bit is checked half a bit after the falling edge was seen.
    function automatic int start_mid_idx(input int oversample);
        return oversample / 2 - 1;
    endfunction

    // Later bits are sampled a full bit period after the previous sample.
    function automatic int bit_centre_idx(input int oversample);
        return oversample - 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2
// Generic two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset; both flops load RESET_VAL
//   i_d    in  asynchronous input
//   o_q    out synchronized output (two clk of latency)
// ----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver: start bit, DATABITS data bits LSB first,
// optional parity bit, one stop bit. Sampling is driven by os_tick at
// OVERSAMPLE ticks per bit.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   rx_in      in   serial line (async to clk, idle high)
//   os_tick    in   oversampling tick, one clk wide
//   rx_data    out  last received word, held until the next frame completes
//   rx_valid   out  one-clk strobe: rx_data / parity_err / frame_err updated
//   parity_err out  parity mismatch on the last frame
//   frame_err  out  stop bit sampled low on the last frame
//   rx_busy    out  high from start-bit detection until frame completion
//
// Optional build macro: UART_RX_MAJORITY_EN
//   Defined  : every bit decision is a 2-of-3 vote over the samples at
//              centre-1, centre and centre+1, taken at the centre+1 tick.
//   Undefined: single sample at the bit centre.
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATABITS    = 8,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_TYPE = 0,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_in,
    input  logic                os_tick,
    output logic [DATABITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATABITS > 1) ? $clog2(DATABITS) : 1;

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the tick after the centre. Every decision moves one
    // tick later, so the start check moves by one and all following bits
    // keep exactly one bit period of spacing.
    localparam int START_IDX = start_mid_idx(OVERSAMPLE) + 1;
`else
    localparam int START_IDX = start_mid_idx(OVERSAMPLE);
`endif

    localparam logic [TW-1:0] TICK_START  = TW'(START_IDX);
    localparam logic [TW-1:0] TICK_CENTRE = TW'(bit_centre_idx(OVERSAMPLE));
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATABITS - 1);
    localparam logic          PAR_ODD     = (PARITY_TYPE != 0);

    uart_rx_state_t      r_state;
    logic [TW-1:0]       r_tick_cnt;
    logic [BW-1:0]       r_bit_cnt;
    logic [DATABITS-1:0] r_shift;
    logic                r_armed;
    logic                r_perr;
    logic [DATABITS-1:0] r_rx_data;
    logic                r_rx_valid;
    logic                r_parity_err;
    logic                r_frame_err;
    logic                r_rx_busy;

    logic                w_rxs;
    logic                w_sample;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_in),
        .o_q   (w_rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    // Line value on the two previous os_ticks; with the current rxs this
    // gives the three samples to vote over.
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= 2'b11;
        end else if (os_tick) begin
            r_hist <= {r_hist[0], w_rxs};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) |
                      (r_hist[1] & w_rxs)     |
                      (r_hist[0] & w_rxs);
`else
    assign w_sample = w_rxs;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_armed      <= 1'b1;
            r_perr       <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_busy    <= 1'b0;
        end else begin
            // The strobe lasts one clk no matter how os_tick is spaced.
            r_rx_valid <= 1'b0;

            if (os_tick) begin
                case (r_state)
                    IDLE: begin
                        r_tick_cnt <= '0;
                        if (w_rxs) begin
                            // Line back high: a break has ended.
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state   <= START;
                            r_rx_busy <= 1'b1;
                        end
                    end

                    START: begin
                        if (r_tick_cnt == TICK_START) begin
                            r_tick_cnt <= '0;
                            if (w_sample) begin
                                // Glitch, not a start bit.
                                r_state   <= IDLE;
                                r_rx_busy <= 1'b0;
                            end else begin
                                r_state   <= DATA;
                                r_bit_cnt <= '0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end

                    DATA: begin
                        if (r_tick_cnt == TICK_CENTRE) begin
                            r_tick_cnt         <= '0;
                            r_shift[r_bit_cnt] <= w_sample;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end

                    PARITY: begin
                        if (r_tick_cnt == TICK_CENTRE) begin
                            r_tick_cnt <= '0;
                            r_perr     <= w_sample ^ par_calc(8'(r_shift), PAR_ODD);
                            r_state    <= STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end

                    STOP: begin
                        // Leave at mid-stop so a back-to-back start edge is
                        // caught with half a bit of margin.
                        if (r_tick_cnt == TICK_CENTRE) begin
                            r_tick_cnt   <= '0;
                            r_rx_data    <= r_shift;
                            r_parity_err <= (PARITY_EN != 0) ? r_perr : 1'b0;
                            r_frame_err  <= ~w_sample;
                            r_rx_valid   <= 1'b1;
                            r_rx_busy    <= 1'b0;
                            r_state      <= IDLE;
                            // A low stop bit may be a break; wait for the
                            // line to go high before accepting a new start.
                            if (!w_sample) begin
                                r_armed <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end

                    default: begin
                        r_state    <= IDLE;
                        r_tick_cnt <= '0;
                        r_rx_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign rx_busy    = r_rx_busy;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Drives 8E1 frames (OVERSAMPLE=16, one os_tick every 4 clk, 64 clk/bit
// nominal) into uart_rx. Expected words are queued when a frame is sent and
// compared when rx_valid fires.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_NOM  = 64;
    localparam int BIT_FAST = 62;
    localparam int BIT_SLOW = 66;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rx_in   = 1'b1;
    logic       os_tick = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .DATABITS    (8),
        .PARITY_EN   (1),
        .PARITY_TYPE (0),
        .OVERSAMPLE  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .os_tick    (os_tick),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // os_tick: one clk high out of every four.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            os_tick = 1'b1;
            @(negedge clk);
            os_tick = 1'b0;
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid) begin
                exp_t e;
                check("valid_pulse_prev", prev_valid, 1'b0);
                if (sb_q.size() == 0) begin
                    check("spurious_valid", rx_valid, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    $display("rx frame data=0x%02h perr=%0b ferr=%0b", rx_data, parity_err, frame_err);
                    check("rx_data", rx_data, e.data);
                    check("parity_err", parity_err, e.perr);
                    check("frame_err", frame_err, e.ferr);
                    check("busy_at_valid", rx_busy, 1'b0);
                end
            end
            prev_valid = rx_valid;
        end
    end

    // Sends one 8E1 frame starting at the next negedge. par_flip inverts the
    // parity bit, stop_val is the stop bit level. If rst_bit >= 0, reset is
    // pulsed for 2 clk in the middle of frame bit rst_bit and the frame is
    // abandoned with the line returned high.
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_val, input int bit_clks,
                              input bit push, input int rst_bit);
        logic [10:0] bits;
        bits = {stop_val, (^d) ^ par_flip, d, 1'b0};
        if (push) sb_q.push_back({d, par_flip, ~stop_val});
        @(negedge clk);
        for (int b = 0; b < 11; b++) begin
            rx_in = bits[b];
            repeat (bit_clks / 2) @(negedge clk);
            if (b == 3) check("busy_mid_frame", rx_busy, 1'b1);
            if (b == rst_bit) begin
                reset = 1'b1;
                #1;
                check("rst_rx_data", rx_data, 8'h00);
                check("rst_rx_valid", rx_valid, 1'b0);
                check("rst_parity_err", parity_err, 1'b0);
                check("rst_frame_err", frame_err, 1'b0);
                check("rst_rx_busy", rx_busy, 1'b0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
                rx_in = 1'b1;
                return;
            end
            repeat (bit_clks - bit_clks / 2) @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("drain_pending", sb_q.size(), 0);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * BIT_NOM) @(negedge clk);
    endtask

    initial begin
        bit seen_busy;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_rx_busy", rx_busy, 1'b0);
        reset = 1'b0;
        idle_bits(2);

        // Clean frame, then check the word is held afterwards.
        send_frame(8'hA5, 1'b0, 1'b1, BIT_NOM, 1'b1, -1);
        drain();
        idle_bits(2);
        check("data_held", rx_data, 8'hA5);
        check("busy_after", rx_busy, 1'b0);

        // Parity bit forced wrong.
        send_frame(8'h3C, 1'b1, 1'b1, BIT_NOM, 1'b1, -1);
        drain();
        idle_bits(1);

        // Low stop bit followed by a 3-bit break, then a normal frame.
        send_frame(8'h81, 1'b0, 1'b0, BIT_NOM, 1'b1, -1);
        repeat (3 * BIT_NOM) @(negedge clk);
        drain();
        idle_bits(2);
        send_frame(8'h55, 1'b0, 1'b1, BIT_NOM, 1'b1, -1);
        drain();
        idle_bits(1);

        // 4-tick glitch on an idle line.
        seen_busy = 1'b0;
        rx_in = 1'b0;
        repeat (16) @(negedge clk);
        rx_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1'b1;
        end
        check("glitch_busy_seen", seen_busy, 1'b1);
        check("glitch_busy_end", rx_busy, 1'b0);
        idle_bits(1);

        // Back-to-back frames, fast then slow transmitter.
        send_frame(8'h00, 1'b0, 1'b1, BIT_FAST, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, BIT_FAST, 1'b1, -1);
        send_frame(8'h5A, 1'b0, 1'b1, BIT_FAST, 1'b1, -1);
        drain();
        idle_bits(1);
        send_frame(8'h00, 1'b0, 1'b1, BIT_SLOW, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, BIT_SLOW, 1'b1, -1);
        send_frame(8'h5A, 1'b0, 1'b1, BIT_SLOW, 1'b1, -1);
        drain();
        idle_bits(1);

        // Reset during data bit 4 (frame bit 5); that frame must vanish.
        send_frame(8'h96, 1'b0, 1'b1, BIT_NOM, 1'b0, 5);
        idle_bits(2);
        check("post_reset_busy", rx_busy, 1'b0);
        send_frame(8'h69, 1'b0, 1'b1, BIT_NOM, 1'b1, -1);
        drain();
        idle_bits(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
